// File: rtl/display_pkg.sv
// display_pkg: shared FSM states, control-word fields and the hex glyph table
// for the dot-matrix display drivers.
package display_pkg;

    typedef enum logic [3:0] {
        RST_ASSERT,
        RST_RELEASE,
        CLEAR,
        LATCH_CLR,
        CTRL,
        LATCH_CTRL,
        LOAD,
        LATCH_DOTS,
        IDLE
    } state_t;

    localparam logic       SLEEP_N = 1'b1;
    localparam logic [1:0] PEAK    = 2'b11;

    // Column-major 5x8 glyphs; bit 39 is the first dot shifted out. Entry 0 is '0'.
    localparam logic [15:0][39:0] GLYPHS = {
        40'b01111111_00001001_00001001_00001001_00000001,
        40'b01111111_01001001_01001001_01001001_01000001,
        40'b01111111_01000001_01000001_01000001_00111110,
        40'b00111110_01000001_01000001_01000001_00100010,
        40'b01111111_01001001_01001001_01001001_00110110,
        40'b01111110_00001001_00001001_00001001_01111110,
        40'b00000110_01001001_01001001_00101001_00011110,
        40'b00110110_01001001_01001001_01001001_00110110,
        40'b00000001_01110001_00001001_00000101_00000011,
        40'b00111100_01001010_01001001_01001001_00110000,
        40'b00100111_01000101_01000101_01000101_00111001,
        40'b00011000_00010100_00010010_01111111_00010000,
        40'b00100010_01000001_01001001_01001001_00110110,
        40'b01100010_01010001_01001001_01001001_01000110,
        40'b00000000_01000010_01111111_01000000_00000000,
        40'b00111110_01010001_01001001_01000101_00111110
    };

    function automatic logic [7:0] ctrl_byte(input logic [3:0] bright);
        return {1'b0, SLEEP_N, PEAK, bright};
    endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// hex_glyph_rom: combinational nibble to 40-bit column-major dot pattern.
module hex_glyph_rom
    import display_pkg::*;
(
    input  logic [3:0]  i_nibble,
    output logic [39:0] o_dots
);

    assign o_dots = GLYPHS[i_nibble];

endmodule

// File: rtl/display_hex_scan.sv
// display_hex_scan: drives a chain of HCMS-style 5x8 dot-matrix characters with hex
// glyphs, with per-character blanking, run-time brightness and tear-free frame snapshots.
module display_hex_scan
    import display_pkg::*;
#(
    parameter int NUM_CHARS  = 16,
    parameter int CLK_DIV    = 27,
    parameter int RESET_HOLD = 100,
    parameter int CONTINUOUS = 1
) (
    input  logic                   clock_27mhz,
    input  logic                   reset,
    input  logic [4*NUM_CHARS-1:0] data,
    input  logic [NUM_CHARS-1:0]   blank_mask,
    input  logic [3:0]             brightness,
    input  logic                   update,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   disp_blank,
    output logic                   disp_clock,
    output logic                   disp_data_out,
    output logic                   disp_rs,
    output logic                   disp_ce_b,
    output logic                   disp_reset_b
);

    localparam int DIV_W     = $clog2(CLK_DIV + 1);
    localparam int HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam int BIT_W     = $clog2(40 * NUM_CHARS);
    localparam int CHAR_W    = $clog2(NUM_CHARS);
    localparam int CTRL_BITS = 8 * (NUM_CHARS / 4);

    state_t                 r_state, w_next;
    logic [DIV_W-1:0]       r_div;
    logic                   r_phase, r_disp_clock, r_frame_done, r_pend;
    logic [HOLD_W-1:0]      r_hold;
    logic [BIT_W-1:0]       r_bit;
    logic [CHAR_W-1:0]      r_char;
    logic [5:0]             r_dot;
    logic [3:0]             r_bright;
    logic [4*NUM_CHARS-1:0] r_frame;
    logic [NUM_CHARS-1:0]   r_blank;
    logic                   w_tick, w_adv, w_last, w_snap, w_bright_chg, w_dot_bit;
    logic [39:0]            w_dots;
    logic [7:0]             w_ctrl;

    assign w_tick       = r_div == DIV_W'(CLK_DIV - 1);
    assign w_adv        = w_tick & ~r_phase;
    assign w_last       = r_bit == '0;
    assign w_snap       = w_adv && w_next == LOAD && r_state != LOAD;
    assign w_bright_chg = brightness != r_bright;
    assign w_ctrl       = ctrl_byte(r_bright);
    assign w_dot_bit    = ~r_blank[r_char] & w_dots[r_dot];
    assign disp_clock   = r_disp_clock;
    assign disp_blank   = 1'b0;
    assign frame_done   = r_frame_done;

    hex_glyph_rom u_rom (
        .i_nibble (r_frame[{r_char, 2'b00} +: 4]),
        .o_dots   (w_dots)
    );

    // Serial outputs move only when phase rises, i.e. on the falling disp_clock edge.
    always_ff @(posedge clock_27mhz or posedge reset) begin
        if (reset) begin
            r_div        <= '0;
            r_phase      <= 1'b0;
            r_disp_clock <= 1'b1;
        end else if (w_tick) begin
            r_div        <= '0;
            r_phase      <= ~r_phase;
            r_disp_clock <= r_phase;
        end else begin
            r_div        <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clock_27mhz or posedge reset) begin
        if (reset)
            r_hold <= HOLD_W'(RESET_HOLD);
        else if (r_hold != '0)
            r_hold <= r_hold - HOLD_W'(1);
    end

    always_ff @(posedge clock_27mhz or posedge reset) begin
        if (reset)
            r_state <= RST_ASSERT;
        else if (w_adv)
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        disp_reset_b  = 1'b1;
        disp_ce_b     = 1'b1;
        disp_rs       = 1'b0;
        disp_data_out = 1'b0;
        busy          = 1'b1;
        case (r_state)
            RST_ASSERT: begin
                disp_reset_b = 1'b0;
                w_next       = (r_hold == '0) ? RST_RELEASE : RST_ASSERT;
            end
            RST_RELEASE: w_next = CLEAR;
            CLEAR: begin
                disp_ce_b = 1'b0;
                w_next    = w_last ? LATCH_CLR : CLEAR;
            end
            LATCH_CLR: begin
                disp_rs = 1'b1;
                w_next  = CTRL;
            end
            CTRL: begin
                disp_ce_b     = 1'b0;
                disp_rs       = 1'b1;
                disp_data_out = w_ctrl[r_bit[2:0]];
                w_next        = w_last ? LATCH_CTRL : CTRL;
            end
            LATCH_CTRL: w_next = LOAD;
            LOAD: begin
                disp_ce_b     = 1'b0;
                disp_data_out = w_dot_bit;
                w_next        = (r_dot == 6'd0 && r_char == '0) ? LATCH_DOTS : LOAD;
            end
            LATCH_DOTS: w_next = w_bright_chg ? CTRL : (CONTINUOUS != 0 || r_pend) ? LOAD : IDLE;
            IDLE: begin
                busy   = 1'b0;
                w_next = w_bright_chg ? CTRL : r_pend ? LOAD : IDLE;
            end
            default: w_next = RST_ASSERT;
        endcase
    end

    always_ff @(posedge clock_27mhz or posedge reset) begin
        if (reset) begin
            r_bit        <= '0;
            r_char       <= '0;
            r_dot        <= '0;
            r_bright     <= '0;
            r_frame      <= '0;
            r_blank      <= '0;
            r_pend       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_adv && r_state == LOAD && w_next == LATCH_DOTS;
            // An update landing on the snapshot cycle is kept for the following frame.
            r_pend       <= w_snap ? update : (r_pend | update);
            if (w_adv) begin
                if (r_state != CLEAR && w_next == CLEAR)
                    r_bit <= BIT_W'(40 * NUM_CHARS - 1);
                else if (r_state != CTRL && w_next == CTRL)
                    r_bit <= BIT_W'(CTRL_BITS - 1);
                else if (!w_last)
                    r_bit <= r_bit - BIT_W'(1);
                if (r_state != CTRL && w_next == CTRL)
                    r_bright <= brightness;
                if (w_snap) begin
                    r_frame <= data;
                    r_blank <= blank_mask;
                    r_char  <= CHAR_W'(NUM_CHARS - 1);
                    r_dot   <= 6'd39;
                end else if (r_state == LOAD) begin
                    r_dot  <= (r_dot == 6'd0) ? 6'd39 : r_dot - 6'd1;
                    r_char <= (r_dot == 6'd0) ? r_char - CHAR_W'(1) : r_char;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_hex_scan.sv
// tb_display_hex_scan: captures every ce_b-framed serial segment and checks it
// against hand-computed control words and an independent glyph/frame model.
module tb_display_hex_scan;

    localparam int NC = 16, CLK_DIV = 2, RESET_HOLD = 10;

    logic clk = 1'b0, reset = 1'b0, update = 1'b0;
    logic [63:0] data = 64'h0123_4567_89AB_CDEF;
    logic [15:0] blank_mask = 16'h0000;
    logic [3:0]  brightness = 4'hF;
    logic busy, frame_done, disp_blank, disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b;

    always #5 clk = ~clk;

    display_hex_scan #(.NUM_CHARS(NC), .CLK_DIV(CLK_DIV), .RESET_HOLD(RESET_HOLD), .CONTINUOUS(0)) dut (
        .clock_27mhz(clk), .reset(reset), .data(data), .blank_mask(blank_mask),
        .brightness(brightness), .update(update), .busy(busy), .frame_done(frame_done),
        .disp_blank(disp_blank), .disp_clock(disp_clock), .disp_data_out(disp_data_out),
        .disp_rs(disp_rs), .disp_ce_b(disp_ce_b), .disp_reset_b(disp_reset_b)
    );

    typedef struct {
        logic       rs;
        int         len;
        logic [639:0] bits;
    } seg_t;

    typedef struct {
        logic [63:0] data;
        logic [15:0] blank;
        logic [39:0] exp_last;
    } vec_t;

    seg_t segq[$];
    logic [639:0] cur = '0;
    int cur_len = 0, n_done = 0, n_checks = 0, n_errors = 0;
    logic cur_rs = 1'b0, prev_dclk = 1'b1, prev_ceb = 1'b1;

    always @(negedge clk) begin
        if (prev_dclk === 1'b0 && disp_clock === 1'b1 && disp_ce_b === 1'b0) begin
            if (cur_len == 0) cur_rs = disp_rs;
            cur = {cur[638:0], disp_data_out};
            cur_len++;
        end
        if (prev_ceb === 1'b0 && disp_ce_b === 1'b1) begin
            segq.push_back('{cur_rs, cur_len, cur});
            cur = '0;
            cur_len = 0;
        end
        if (frame_done === 1'b1) n_done++;
        prev_dclk = disp_clock;
        prev_ceb = disp_ce_b;
    end

    function automatic logic [39:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 40'h3E_51_49_45_3E;
            4'h1: return 40'h00_42_7F_40_00;
            4'h2: return 40'h62_51_49_49_46;
            4'h3: return 40'h22_41_49_49_36;
            4'h4: return 40'h18_14_12_7F_10;
            4'h5: return 40'h27_45_45_45_39;
            4'h6: return 40'h3C_4A_49_49_30;
            4'h7: return 40'h01_71_09_05_03;
            4'h8: return 40'h36_49_49_49_36;
            4'h9: return 40'h06_49_49_29_1E;
            4'hA: return 40'h7E_09_09_09_7E;
            4'hB: return 40'h7F_49_49_49_36;
            4'hC: return 40'h3E_41_41_41_22;
            4'hD: return 40'h7F_41_41_41_3E;
            4'hE: return 40'h7F_49_49_49_41;
            default: return 40'h7F_09_09_09_01;
        endcase
    endfunction

    // First shifted dot (char 15, dot 39) lands in bit 639 of a captured segment.
    function automatic logic [639:0] frame_bits(input logic [63:0] d, input logic [15:0] b);
        logic [639:0] r = '0;
        for (int c = 0; c < 16; c++)
            if (!b[c]) r[40*c +: 40] = glyph(d[4*c +: 4]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_seg(input string nm, input logic rs, input int len,
                             input logic [639:0] exp, output logic [639:0] bits);
        seg_t s;
        bits = '0;
        n_checks++;
        if (segq.size() == 0) begin
            n_errors++;
            $display("FAIL %s: got no segment expected one", nm);
            return;
        end
        n_checks--;
        s = segq.pop_front();
        bits = s.bits;
        chk({nm, "_rs"}, s.rs, rs);
        chk({nm, "_len"}, s.len, len);
        chk({nm, "_bits"}, s.bits, exp);
    endtask

    task automatic settle(input int n, input int budget);
        int c = 0;
        while ((segq.size() < n || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("settle_in_time", c < budget, 1);
        repeat (40) @(negedge clk);
        chk("seg_count", segq.size(), n);
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_ce_low(input int budget);
        int c = 0;
        while (disp_ce_b !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("ce_low_in_time", c < budget, 1);
    endtask

    task automatic pulse_update();
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
    endtask

    vec_t vecs[4];
    logic [639:0] got;
    logic [63:0] old_data;
    int d0, cnt;

    initial begin
        vecs[0] = '{64'hFEDC_BA98_7654_3218, 16'h0001, 40'h0};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 16'h0000, 40'h7F_09_09_09_01};
        vecs[2] = '{64'h8888_8888_8888_8888, 16'h8000, 40'h36_49_49_49_36};
        vecs[3] = '{64'hA5A5_A5A5_A5A5_A5A5, 16'hFFFF, 40'h0};

        #2 reset = 1'b1;
        #1;
        chk("rst_outputs", {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, busy, frame_done, disp_clock, disp_blank},
            8'b0100_1010);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (!disp_reset_b && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_hold_len", cnt >= RESET_HOLD && cnt <= RESET_HOLD + 4 * CLK_DIV - 2, 1);
        chk("ce_b_at_release", disp_ce_b, 1);

        settle(3, 20000);
        check_seg("init_clear", 1'b0, 640, '0, got);
        check_seg("init_ctrl", 1'b1, 32, 640'h7F7F7F7F, got);
        check_seg("init_frame", 1'b0, 640, frame_bits(data, blank_mask), got);
        chk("init_frames", n_done, 1);

        for (int i = 0; i < 4; i++) begin
            data = vecs[i].data;
            blank_mask = vecs[i].blank;
            d0 = n_done;
            pulse_update();
            settle(1, 8000);
            check_seg($sformatf("vec%0d", i), 1'b0, 640, frame_bits(vecs[i].data, vecs[i].blank), got);
            chk($sformatf("vec%0d_last40", i), got[39:0], vecs[i].exp_last);
            chk($sformatf("vec%0d_done", i), n_done - d0, 1);
        end

        data = 64'h0123_4567_89AB_CDEF;
        blank_mask = 16'h0000;
        d0 = n_done;
        pulse_update();
        wait_ce_low(100);
        repeat (100) @(negedge clk);
        pulse_update();
        repeat (100) @(negedge clk);
        pulse_update();
        settle(2, 12000);
        check_seg("merge_f1", 1'b0, 640, frame_bits(data, blank_mask), got);
        check_seg("merge_f2", 1'b0, 640, frame_bits(data, blank_mask), got);
        chk("merge_done", n_done - d0, 2);

        old_data = data;
        d0 = n_done;
        pulse_update();
        wait_ce_low(100);
        repeat (200) @(negedge clk);
        brightness = 4'h3;
        data = 64'hFFFF_0000_AAAA_5555;
        settle(3, 12000);
        check_seg("mid_old_frame", 1'b0, 640, frame_bits(old_data, blank_mask), got);
        check_seg("bright_ctrl", 1'b1, 32, 640'h73737373, got);
        check_seg("bright_frame", 1'b0, 640, frame_bits(data, blank_mask), got);
        chk("bright_done", n_done - d0, 2);

        brightness = 4'hA;
        wait_ce_low(100);
        chk("ctrl_rs", disp_rs, 1);
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_outputs", {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, busy, frame_done, disp_clock},
            7'b0100_101);
        repeat (3) @(negedge clk);
        segq.delete();
        d0 = n_done;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_reset_b_low", disp_reset_b, 0);
        settle(3, 20000);
        check_seg("reinit_clear", 1'b0, 640, '0, got);
        check_seg("reinit_ctrl", 1'b1, 32, 640'h7A7A7A7A, got);
        check_seg("reinit_frame", 1'b0, 640, frame_bits(data, blank_mask), got);
        chk("reinit_done", n_done - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
